// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM/WB pipeline register with a valid/ready handshake and a one-entry skid buffer.
// Optional macro MEM_WB_FWD_EN adds the fwd_valid/fwd_dest/fwd_value forwarding tap.
// The main slot drives the outputs. The skid slot catches the one entry accepted while the
// main slot is stalled. Because of this, in_ready depends only on skid occupancy and not on out_ready.
module mem_wb_pipe_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int DEST_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  WB_en_in,
   input  logic                  MEM_R_en_in,
   input  logic [DATA_WIDTH-1:0] ALU_result_in,
   input  logic [DATA_WIDTH-1:0] Mem_read_value_in,
   input  logic [DEST_WIDTH-1:0] Dest_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  WB_en,
   output logic                  MEM_R_en,
   output logic [DATA_WIDTH-1:0] ALU_result,
   output logic [DATA_WIDTH-1:0] Mem_read_value,
   output logic [DEST_WIDTH-1:0] Dest,
   output logic [DATA_WIDTH-1:0] wb_value
`ifdef MEM_WB_FWD_EN
   ,
   output logic                  fwd_valid,
   output logic [DEST_WIDTH-1:0] fwd_dest,
   output logic [DATA_WIDTH-1:0] fwd_value
`endif
);
   // The payload is packed as {WB_en, MEM_R_en, ALU_result, Mem_read_value, Dest}.
   localparam int PW = 2 + 2 * DATA_WIDTH + DEST_WIDTH;
   logic          m_valid_q, m_valid_d, s_valid_q, s_valid_d;
   logic [PW-1:0] m_pl_q, m_pl_d, s_pl_q, s_pl_d, in_pl;
   logic          in_fire, m_free, m_wb, m_mr;
   assign in_pl   = {WB_en_in, MEM_R_en_in, ALU_result_in, Mem_read_value_in, Dest_in};
   assign in_ready = !s_valid_q;
   assign in_fire = in_valid & in_ready;
   // The main slot can take a new entry when it is empty or its entry leaves this cycle.
   assign m_free  = !m_valid_q | out_ready;
   assign {m_wb, m_mr, ALU_result, Mem_read_value, Dest} = m_pl_q;
   assign out_valid = m_valid_q;
   assign WB_en     = m_valid_q & m_wb;
   assign MEM_R_en  = m_valid_q & m_mr;
   assign wb_value  = MEM_R_en ? Mem_read_value : ALU_result;
`ifdef MEM_WB_FWD_EN
   assign fwd_valid = WB_en;
   assign fwd_dest  = Dest;
   assign fwd_value = wb_value;
`endif
   // Next state: flush kills both slots. A freed main slot refills from skid first, then from input.
   // A stalled main slot diverts an accepted input into skid.
   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_pl_d    = m_pl_q;
      s_pl_d    = s_pl_q;
      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (m_free) begin
         m_valid_d = s_valid_q | in_fire;
         m_pl_d    = s_valid_q ? s_pl_q : (in_fire ? in_pl : m_pl_q);
         s_valid_d = 1'b0;
      end else if (in_fire) begin
         s_valid_d = 1'b1;
         s_pl_d    = in_pl;
      end
   end
   // State registers with synchronous active-low reset clearing valids and payloads.
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         m_pl_q    <= '0;
         s_pl_q    <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         m_pl_q    <= m_pl_d;
         s_pl_q    <= s_pl_d;
      end
   end
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: directed vector table plus randomized run against a depth-2 FIFO model.
module tb_mem_wb_pipe_reg;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, WB_en_in, MEM_R_en_in, out_valid, out_ready;
   logic        WB_en, MEM_R_en;
   logic [31:0] ALU_result_in, Mem_read_value_in, ALU_result, Mem_read_value, wb_value;
   logic [3:0]  Dest_in, Dest;
`ifdef MEM_WB_FWD_EN
   logic        fwd_valid;
   logic [3:0]  fwd_dest;
   logic [31:0] fwd_value;
`endif
   int errors = 0;
   int checks = 0;

   mem_wb_pipe_reg #(.DATA_WIDTH(32), .DEST_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in), .ALU_result_in(ALU_result_in),
      .Mem_read_value_in(Mem_read_value_in), .Dest_in(Dest_in), .out_valid(out_valid),
      .out_ready(out_ready), .WB_en(WB_en), .MEM_R_en(MEM_R_en), .ALU_result(ALU_result),
      .Mem_read_value(Mem_read_value), .Dest(Dest), .wb_value(wb_value)
`ifdef MEM_WB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, flush, iv, wb, mr, ordy;
      logic [31:0] alu, mem;
      logic [3:0]  dest;
      logic        e_ov, e_ir, e_wb, e_mr, chk;
      logic [31:0] e_val, e_alu;
      logic [3:0]  e_dest;
   } vec_t;

   typedef struct {
      logic        wb, mr;
      logic [31:0] alu, mem;
      logic [3:0]  dest;
   } ent_t;

   vec_t vecs[$];
   ent_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic r, input logic f, input logic iv, input logic wb,
                              input logic mr, input logic ordy, input logic [31:0] alu,
                              input logic [31:0] mem, input logic [3:0] dest, input logic e_ov,
                              input logic e_ir, input logic e_wb, input logic e_mr,
                              input logic c, input logic [31:0] e_val, input logic [31:0] e_alu,
                              input logic [3:0] e_dest);
      vec_t x;
      x.rst = r; x.flush = f; x.iv = iv; x.wb = wb; x.mr = mr; x.ordy = ordy;
      x.alu = alu; x.mem = mem; x.dest = dest; x.e_ov = e_ov; x.e_ir = e_ir;
      x.e_wb = e_wb; x.e_mr = e_mr; x.chk = c; x.e_val = e_val; x.e_alu = e_alu;
      x.e_dest = e_dest;
      return x;
   endfunction

   task automatic drive(input logic r, input logic f, input logic iv, input logic wb,
                        input logic mr, input logic ordy, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [3:0] dest);
      rst = r; flush = f; in_valid = iv; WB_en_in = wb; MEM_R_en_in = mr; out_ready = ordy;
      ALU_result_in = alu; Mem_read_value_in = mem; Dest_in = dest;
      @(posedge clk);
      #1;
   endtask

   // Model step: acceptance uses pre-edge occupancy. The head pops when consumed, then the input is appended.
   task automatic model_step(input logic r, input logic f, input logic iv, input logic ordy,
                             input ent_t e);
      logic acc;
      acc = iv && q.size() < 2;
      if (!r || f) q.delete();
      else begin
         if (q.size() > 0 && ordy) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
   endtask

   task automatic model_check();
      chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      chk("rnd_wb_en", {31'b0, WB_en}, {31'b0, q.size() > 0 && q[0].wb});
      chk("rnd_mem_r_en", {31'b0, MEM_R_en}, {31'b0, q.size() > 0 && q[0].mr});
      if (q.size() > 0) begin
         chk("rnd_alu", ALU_result, q[0].alu);
         chk("rnd_mem", Mem_read_value, q[0].mem);
         chk("rnd_dest", {28'b0, Dest}, {28'b0, q[0].dest});
         chk("rnd_wb_value", wb_value, q[0].mr ? q[0].mem : q[0].alu);
      end
`ifdef MEM_WB_FWD_EN
      chk("rnd_fwd_valid", {31'b0, fwd_valid}, {31'b0, q.size() > 0 && q[0].wb});
      if (q.size() > 0) begin
         chk("rnd_fwd_dest", {28'b0, fwd_dest}, {28'b0, q[0].dest});
         chk("rnd_fwd_value", fwd_value, q[0].mr ? q[0].mem : q[0].alu);
      end
`endif
   endtask

   initial begin
      // Columns: rst flush iv wb mr ordy alu mem dest | ov ir wb mr chk val alu dest
      // reset held with in_valid high
      vecs.push_back(v(0,0,1,1,1,1,32'h99,32'h98,4'h9, 0,1,0,0,1,32'h0,32'h0,4'h0));
      vecs.push_back(v(0,0,1,1,1,1,32'h99,32'h98,4'h9, 0,1,0,0,1,32'h0,32'h0,4'h0));
      // streaming
      vecs.push_back(v(1,0,1,1,0,1,32'h11,32'h0,4'h1, 1,1,1,0,1,32'h11,32'h11,4'h1));
      vecs.push_back(v(1,0,1,1,0,1,32'h22,32'h0,4'h2, 1,1,1,0,1,32'h22,32'h22,4'h2));
      vecs.push_back(v(1,0,1,1,0,1,32'h33,32'h0,4'h3, 1,1,1,0,1,32'h33,32'h33,4'h3));
      // load select
      vecs.push_back(v(1,0,1,1,1,1,32'h1000,32'hDEADBEEF,4'h4, 1,1,1,1,1,32'hDEADBEEF,32'h1000,4'h4));
      // drain
      vecs.push_back(v(1,0,0,0,0,1,32'h0,32'h0,4'h0, 0,1,0,0,0,32'h0,32'h0,4'h0));
      // backpressure: A, B, C held, then release
      vecs.push_back(v(1,0,1,1,0,0,32'hA1,32'h0,4'h5, 1,1,1,0,1,32'hA1,32'hA1,4'h5));
      vecs.push_back(v(1,0,1,1,0,0,32'hB2,32'h0,4'h6, 1,0,1,0,1,32'hA1,32'hA1,4'h5));
      vecs.push_back(v(1,0,1,1,0,0,32'hC3,32'h0,4'h7, 1,0,1,0,1,32'hA1,32'hA1,4'h5));
      vecs.push_back(v(1,0,1,1,0,1,32'hC3,32'h0,4'h7, 1,1,1,0,1,32'hB2,32'hB2,4'h6));
      vecs.push_back(v(1,0,1,1,0,1,32'hC3,32'h0,4'h7, 1,1,1,0,1,32'hC3,32'hC3,4'h7));
      vecs.push_back(v(1,0,0,0,0,1,32'h0,32'h0,4'h0, 0,1,0,0,0,32'h0,32'h0,4'h0));
      // flush with both slots full and in_valid high
      vecs.push_back(v(1,0,1,1,1,0,32'hD4,32'hD5,4'h8, 1,1,1,1,1,32'hD5,32'hD4,4'h8));
      vecs.push_back(v(1,0,1,1,0,0,32'hE5,32'h0,4'h9, 1,0,1,1,1,32'hD5,32'hD4,4'h8));
      vecs.push_back(v(1,1,1,1,0,0,32'hF6,32'h0,4'hA, 0,1,0,0,0,32'h0,32'h0,4'h0));
      vecs.push_back(v(1,0,0,0,0,1,32'h0,32'h0,4'h0, 0,1,0,0,0,32'h0,32'h0,4'h0));
      // flush discards an input that would otherwise be accepted
      vecs.push_back(v(1,1,1,1,0,1,32'h6A,32'h0,4'hB, 0,1,0,0,0,32'h0,32'h0,4'h0));
      vecs.push_back(v(1,0,0,0,0,1,32'h0,32'h0,4'h0, 0,1,0,0,0,32'h0,32'h0,4'h0));
      // reset mid-stall, then 0x55 passes in one cycle
      vecs.push_back(v(1,0,1,1,0,0,32'h71,32'h0,4'h1, 1,1,1,0,1,32'h71,32'h71,4'h1));
      vecs.push_back(v(1,0,1,1,0,0,32'h72,32'h0,4'h2, 1,0,1,0,1,32'h71,32'h71,4'h1));
      vecs.push_back(v(0,0,0,0,0,0,32'h0,32'h0,4'h0, 0,1,0,0,1,32'h0,32'h0,4'h0));
      vecs.push_back(v(1,0,1,1,0,0,32'h55,32'h0,4'h7, 1,1,1,0,1,32'h55,32'h55,4'h7));
      vecs.push_back(v(1,0,0,0,0,1,32'h0,32'h0,4'h0, 0,1,0,0,0,32'h0,32'h0,4'h0));
      // WB_en gated by the held enable
      vecs.push_back(v(1,0,1,0,0,1,32'h77,32'h0,4'h3, 1,1,0,0,1,32'h77,32'h77,4'h3));
      vecs.push_back(v(1,0,0,0,0,1,32'h0,32'h0,4'h0, 0,1,0,0,0,32'h0,32'h0,4'h0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].wb, vecs[i].mr, vecs[i].ordy,
               vecs[i].alu, vecs[i].mem, vecs[i].dest);
         chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
         chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
         chk($sformatf("v%0d_wb_en", i), {31'b0, WB_en}, {31'b0, vecs[i].e_wb});
         chk($sformatf("v%0d_mem_r_en", i), {31'b0, MEM_R_en}, {31'b0, vecs[i].e_mr});
         if (vecs[i].chk) begin
            chk($sformatf("v%0d_wb_value", i), wb_value, vecs[i].e_val);
            chk($sformatf("v%0d_alu", i), ALU_result, vecs[i].e_alu);
            chk($sformatf("v%0d_dest", i), {28'b0, Dest}, {28'b0, vecs[i].e_dest});
         end
      end

      // randomized run against the FIFO model, starting from a reset
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
      q.delete();
      for (int n = 0; n < 600; n++) begin
         ent_t e;
         logic r, f, iv, ordy;
         r    = ($urandom_range(0, 39) != 0);
         f    = ($urandom_range(0, 15) == 0);
         iv   = ($urandom_range(0, 1) == 1);
         ordy = ($urandom_range(0, 9) < 6);
         e.wb = 1'($urandom);
         e.mr = 1'($urandom);
         e.alu = $urandom;
         e.mem = $urandom;
         e.dest = 4'($urandom);
         model_step(r, f, iv, ordy, e);
         drive(r, f, iv, e.wb, e.mr, ordy, e.alu, e.mem, e.dest);
         model_check();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
